johnson_phase_monitor: RTL

Consumes the 4-bit Johnson count produced by the adjacent Johnson counter stage. Each cycle it checks that the code is one of the 8 legal Johnson states and that each step is legal. It decodes the code to a 3-bit phase index and a one-hot phase strobe, counts full revolutions, and flags corruption. It sits directly downstream of the counter and drives the phase-sequenced logic that follows.

---
 rtl/johnson_pkg.sv | 18 +
 rtl/johnson_decode.sv | 27 ++
 rtl/johnson_phase_monitor.sv | 134 +++++++++++++
 3 files changed

// File: rtl/johnson_pkg.sv
// Shared types, sizes and helpers for the Johnson phase monitor.
package johnson_pkg;

  localparam int JOHNSON_W  = 4;
  localparam int NUM_PHASES = 8;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    LOCKED = 2'd1,
    ERR    = 2'd2
  } state_t;

  // Code the upstream counter produces one step after c.
  function automatic logic [JOHNSON_W-1:0] next_code(input logic [JOHNSON_W-1:0] c);
    return {c[JOHNSON_W-2:0], ~c[JOHNSON_W-1]};
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code to phase-index decoder with legality flag.
module johnson_decode
  import johnson_pkg::*;
(
  input  logic [JOHNSON_W-1:0] i_code,
  output logic [2:0]           o_phase,
  output logic                 o_legal
);

  // Map the 8 legal codes to their phase; all others are illegal.
  always_comb begin
    o_phase = 3'd0;
    o_legal = 1'b1;
    case (i_code)
      4'b0000: o_phase = 3'd0;
      4'b0001: o_phase = 3'd1;
      4'b0011: o_phase = 3'd2;
      4'b0111: o_phase = 3'd3;
      4'b1111: o_phase = 3'd4;
      4'b1110: o_phase = 3'd5;
      4'b1100: o_phase = 3'd6;
      4'b1000: o_phase = 3'd7;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Johnson count monitor: checks code/step legality, acquires lock, decodes
// the phase, counts revolutions and flags corruption once locked.
//
//   state  | meaning
//   ACQ    | counting consecutive legal steps toward lock; faults just restart
//   LOCKED | phase outputs valid; any fault goes to ERR
//   ERR    | outputs invalid, rev_count frozen; err_clr returns to ACQ
module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int REV_W      = 8,
  parameter int ALLOW_HOLD = 0
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic [JOHNSON_W-1:0]  Count_in,
  input  logic                  err_clr,
  output logic [2:0]            phase,
  output logic [NUM_PHASES-1:0] phase_onehot,
  output logic                  phase_valid,
  output logic                  locked,
  output logic                  rev_tick,
  output logic [REV_W-1:0]      rev_count,
  output logic                  illegal_err
);

  state_t                  r_state;
  logic [3:0]              r_acq;
  logic [JOHNSON_W-1:0]    r_prev;
  logic [2:0]              r_phase;
  logic [NUM_PHASES-1:0]   r_onehot;
  logic                    r_valid;
  logic                    r_tick;
  logic [REV_W-1:0]        r_rev;
  logic                    r_err;

  state_t                  w_state_nxt;
  logic [3:0]              w_acq_nxt;
  logic [3:0]              w_acq_inc;
  logic                    w_tick_nxt;
  logic                    w_err_nxt;
  logic [2:0]              w_phase;
  logic                    w_cur_legal;
  logic                    w_adv;
  logic                    w_hold;
  logic                    w_ok;
  logic                    w_wrap;

  johnson_decode u_dec (
    .i_code  (Count_in),
    .o_phase (w_phase),
    .o_legal (w_cur_legal)
  );

  // An illegal prev can never shift into a legal code, so checking cur suffices.
  assign w_adv     = w_cur_legal && (Count_in == next_code(r_prev));
  assign w_hold    = (ALLOW_HOLD != 0) && w_cur_legal && (Count_in == r_prev);
  assign w_ok      = w_adv || w_hold;
  assign w_wrap    = w_adv && (r_prev == 4'b1000);
  assign w_acq_inc = r_acq + 4'd1;

  // Next-state, acquisition counter, tick and sticky error decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_acq_nxt   = r_acq;
    w_tick_nxt  = 1'b0;
    w_err_nxt   = r_err;
    case (r_state)
      ACQ: begin
        if (w_adv) begin
          if (w_acq_inc == 4'(LOCK_CNT)) begin
            w_state_nxt = LOCKED;
            w_acq_nxt   = 4'd0;
          end else begin
            w_acq_nxt = w_acq_inc;
          end
        end else if (!w_hold) begin
          w_acq_nxt = 4'd0;
        end
      end
      LOCKED: begin
        if (!w_ok) begin
          w_state_nxt = ERR;
          w_err_nxt   = 1'b1;
        end else begin
          w_tick_nxt = w_wrap;
        end
      end
      ERR: begin
        if (err_clr) begin
          w_state_nxt = ACQ;
          w_acq_nxt   = 4'd0;
          w_err_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = ACQ;
    endcase
  end

  // State, history and registered outputs.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state  <= ACQ;
      r_acq    <= 4'd0;
      r_prev   <= '0;
      r_phase  <= 3'd0;
      r_onehot <= '0;
      r_valid  <= 1'b0;
      r_tick   <= 1'b0;
      r_rev    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acq    <= w_acq_nxt;
      r_prev   <= Count_in;
      r_valid  <= (w_state_nxt == LOCKED);
      r_onehot <= (w_state_nxt == LOCKED) ? (NUM_PHASES'(1) << w_phase) : '0;
      r_tick   <= w_tick_nxt;
      r_err    <= w_err_nxt;
      if (w_state_nxt != ERR && w_cur_legal) r_phase <= w_phase;
      if (w_tick_nxt) r_rev <= r_rev + REV_W'(1);
    end
  end

  assign phase        = r_phase;
  assign phase_onehot = r_onehot;
  assign phase_valid  = r_valid;
  assign locked       = (r_state == LOCKED);
  assign rev_tick     = r_tick;
  assign rev_count    = r_rev;
  assign illegal_err  = r_err;

endmodule
